render_frame_scheduler: RTL

Sequencer in front of the pipelined torus renderer. It produces lookahead pixel coordinates, so the renderer starts pixel N while the display shows pixel N-LEAD. It owns the scene/camera configuration: host updates are accepted through a valid/ready handshake and committed only at the vblank boundary, so a frame never tears. It also auto-rotates the camera once per frame and emits frame-level status.

---
 rtl/render_frame_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/render_frame_scheduler.sv
// Frame sequencer for the pipelined torus renderer: lookahead coordinates,
// tear-free config commit at the vblank boundary, auto-rotation and frame status.
module render_frame_scheduler #(
    parameter int H_TOTAL   = 800,
    parameter int V_TOTAL   = 525,
    parameter int V_DISPLAY = 480,
    parameter int LEAD      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] h_count,
    input  logic [9:0]  v_count,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_scene,
    input  logic [15:0] cfg_angle,
    input  logic        auto_rotate,
    input  logic [15:0] rotate_step,
    output logic [10:0] render_h,
    output logic [9:0]  render_v,
    output logic [1:0]  scene_select,
    output logic [15:0] cam_angle,
    output logic        in_vblank,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    typedef enum logic [0:0] {ACTIVE, VBLANK} state_t;

    state_t      state_reg, state_next;
    logic [10:0] render_h_reg, render_h_next;
    logic [9:0]  render_v_reg, render_v_next;
    logic [9:0]  v_prev_reg;
    logic [1:0]  scene_reg, scene_next;
    logic [15:0] angle_reg, angle_next;
    logic [1:0]  shadow_scene_reg, shadow_scene_next;
    logic [15:0] shadow_angle_reg, shadow_angle_next;
    logic        pending_reg, pending_next;
    logic [7:0]  frame_count_reg, frame_count_next;
    logic        frame_start_reg, frame_start_next;
    logic        in_vblank_reg;

    logic [11:0] sum;
    logic [11:0] sum_wrap;
    logic [10:0] v_inc;
    logic        enter_vb;
    logic        enter_fr;
    logic        transfer;

    // Lookahead: a sum past the line end wraps onto the next line (and frame).
    always_comb begin
        sum           = {1'b0, h_count} + 12'(LEAD);
        sum_wrap      = sum - 12'(H_TOTAL);
        v_inc         = {1'b0, v_count} + 11'd1;
        render_h_next = sum[10:0];
        render_v_next = v_count;
        if (sum >= 12'(H_TOTAL)) begin
            render_h_next = sum_wrap[10:0];
            render_v_next = (v_inc == 11'(V_TOTAL)) ? 10'd0 : v_inc[9:0];
        end
    end

    // Edge detect on the line counter so multi-clock pixel cadences fire once.
    assign enter_vb = (v_count == 10'(V_DISPLAY)) && (v_prev_reg != 10'(V_DISPLAY));
    assign enter_fr = (v_count == 10'd0) && (v_prev_reg != 10'd0);
    assign transfer = cfg_valid && !pending_reg;

    always_comb begin
        state_next        = state_reg;
        scene_next        = scene_reg;
        angle_next        = angle_reg;
        shadow_scene_next = shadow_scene_reg;
        shadow_angle_next = shadow_angle_reg;
        pending_next      = pending_reg;
        frame_count_next  = frame_count_reg;
        frame_start_next  = 1'b0;

        // A transfer on the boundary clock only fills the shadow; it applies next frame.
        if (transfer) begin
            shadow_scene_next = cfg_scene;
            shadow_angle_next = cfg_angle;
            pending_next      = 1'b1;
        end

        case (state_reg)
            ACTIVE: begin
                if (enter_vb) begin
                    state_next       = VBLANK;
                    frame_count_next = frame_count_reg + 8'd1;
                    if (pending_reg) begin
                        scene_next   = shadow_scene_reg;
                        angle_next   = shadow_angle_reg;
                        pending_next = 1'b0;
                    end else if (auto_rotate) begin
                        angle_next = angle_reg + rotate_step;
                    end
                end
            end
            VBLANK: begin
                if (enter_fr) begin
                    state_next       = ACTIVE;
                    frame_start_next = 1'b1;
                end
            end
            default: state_next = ACTIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ACTIVE;
            render_h_reg     <= '0;
            render_v_reg     <= '0;
            v_prev_reg       <= '0;
            scene_reg        <= '0;
            angle_reg        <= '0;
            shadow_scene_reg <= '0;
            shadow_angle_reg <= '0;
            pending_reg      <= 1'b0;
            frame_count_reg  <= '0;
            frame_start_reg  <= 1'b0;
            in_vblank_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            render_h_reg     <= render_h_next;
            render_v_reg     <= render_v_next;
            v_prev_reg       <= v_count;
            scene_reg        <= scene_next;
            angle_reg        <= angle_next;
            shadow_scene_reg <= shadow_scene_next;
            shadow_angle_reg <= shadow_angle_next;
            pending_reg      <= pending_next;
            frame_count_reg  <= frame_count_next;
            frame_start_reg  <= frame_start_next;
            in_vblank_reg    <= (state_next == VBLANK);
        end
    end

    assign cfg_ready    = !pending_reg;
    assign render_h     = render_h_reg;
    assign render_v     = render_v_reg;
    assign scene_select = scene_reg;
    assign cam_angle    = angle_reg;
    assign in_vblank    = in_vblank_reg;
    assign frame_start  = frame_start_reg;
    assign frame_count  = frame_count_reg;

endmodule
